// File: rtl/assignment_pkg.sv
// assignment_pkg: shared constants for the registered 4-input truth-table function.
package assignment_pkg;
  localparam int IDX_W = 4;
  localparam int TT_W = 2 ** IDX_W;
  localparam logic [TT_W-1:0] TRUTH_TABLE_DEFAULT = 16'hF222;
endpackage

// File: rtl/assignment_lut.sv
// assignment_lut: combinational 16:1 truth-table lookup built as a 2:1 mux tree.
module assignment_lut
  import assignment_pkg::*;
#(
  parameter logic [TT_W-1:0] TRUTH_TABLE = TRUTH_TABLE_DEFAULT
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic             f_o
);
  logic [7:0] l1;
  logic [3:0] l2;
  logic [1:0] l3;
  // Each level consumes one index bit, LSB (D) first.
  for (genvar i = 0; i < 8; i++) begin : g_l1
    assign l1[i] = idx_i[0] ? TRUTH_TABLE[2*i+1] : TRUTH_TABLE[2*i];
  end
  for (genvar i = 0; i < 4; i++) begin : g_l2
    assign l2[i] = idx_i[1] ? l1[2*i+1] : l1[2*i];
  end
  for (genvar i = 0; i < 2; i++) begin : g_l3
    assign l3[i] = idx_i[2] ? l2[2*i+1] : l2[2*i];
  end
  assign f_o = idx_i[3] ? l3[1] : l3[0];
endmodule

// File: rtl/assignment.sv
// assignment: registered lookup F = TRUTH_TABLE[{A,B,C,D}] with one cycle latency.
module assignment
  import assignment_pkg::*;
#(
  parameter logic [TT_W-1:0] TRUTH_TABLE = TRUTH_TABLE_DEFAULT
) (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic F,
  input  logic clk,
  input  logic rst
);
  logic f_d, f_q;
  assignment_lut #(.TRUTH_TABLE(TRUTH_TABLE)) u_lut (
    .idx_i({A, B, C, D}),
    .f_o  (f_d)
  );
  always_ff @(posedge clk) begin
    if (rst) f_q <= 1'b0;
    else     f_q <= f_d;
  end
  assign F = f_q;
endmodule

// File: tb/tb_assignment.sv
// tb_assignment: checks default and overridden truth tables against a boolean reference model.
module tb_assignment;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] idx = 4'd0;
  logic f_def, f_and;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assignment dut (
    .A(idx[3]), .B(idx[2]), .C(idx[1]), .D(idx[0]), .F(f_def), .clk(clk), .rst(rst)
  );
  assignment #(.TRUTH_TABLE(16'h8000)) dut_and (
    .A(idx[3]), .B(idx[2]), .C(idx[1]), .D(idx[0]), .F(f_and), .clk(clk), .rst(rst)
  );

  function automatic logic ref_def(input logic [3:0] i);
    return (i[3] & i[2]) | (~i[1] & i[0]);
  endfunction

  function automatic logic ref_and(input logic [3:0] i);
    return i == 4'd15;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idx = 4'd15;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (f_def !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold edge%0d: F=%b expected 0", k, f_def);
      end
      n_cmp++;
      if (f_and !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold_and edge%0d: F=%b expected 0", k, f_and);
      end
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (f_def !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: F=%b expected 1", f_def);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      step();
      step();
      n_cmp++;
      if (f_def !== ref_def(4'(i))) begin
        n_err++;
        $display("FAIL sweep_default idx=%0d: F=%b expected %b", i, f_def, ref_def(4'(i)));
      end
      n_cmp++;
      if (f_and !== ref_and(4'(i))) begin
        n_err++;
        $display("FAIL sweep_override idx=%0d: F=%b expected %b", i, f_and, ref_and(4'(i)));
      end
    end
  endtask

  task automatic test_latency();
    idx = 4'd0;
    step();
    idx = 4'd13;
    #3;
    n_cmp++;
    if (f_def !== 1'b0) begin
      n_err++;
      $display("FAIL latency_before_edge: F=%b expected 0", f_def);
    end
    step();
    n_cmp++;
    if (f_def !== 1'b1) begin
      n_err++;
      $display("FAIL latency_after_edge: F=%b expected 1", f_def);
    end
  endtask

  task automatic test_glitch();
    idx = 4'd0;
    step();
    idx = 4'd1;
    #3;
    idx = 4'd0;
    step();
    n_cmp++;
    if (f_def !== 1'b0) begin
      n_err++;
      $display("FAIL glitch: F=%b expected 0", f_def);
    end
  endtask

  task automatic test_reset_mid();
    idx = 4'd12;
    step();
    rst = 1'b1;
    step();
    n_cmp++;
    if (f_def !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_assert: F=%b expected 0", f_def);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (f_def !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_release: F=%b expected 1", f_def);
    end
  endtask

  task automatic test_random();
    logic exp_def, exp_and;
    for (int k = 0; k < 300; k++) begin
      idx = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 7) == 0);
      exp_def = rst ? 1'b0 : ref_def(idx);
      exp_and = rst ? 1'b0 : ref_and(idx);
      step();
      n_cmp++;
      if (f_def !== exp_def) begin
        n_err++;
        $display("FAIL random_default k=%0d idx=%0d rst=%b: F=%b expected %b", k, idx, rst, f_def, exp_def);
      end
      n_cmp++;
      if (f_and !== exp_and) begin
        n_err++;
        $display("FAIL random_override k=%0d idx=%0d rst=%b: F=%b expected %b", k, idx, rst, f_and, exp_and);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_latency();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
